// File: rtl/food_spawner.sv
// Food placement: samples a random coordinate, snaps it to the play grid, and confirms the cell is free with the occupancy checker.
// Optional FOOD_SCAN_FALLBACK_EN: once the random tries are used up, walk the grid cell by cell instead of failing straight away.
module food_spawner #(
    parameter int unsigned GRID      = 20,
    parameter int unsigned X_MIN     = 20,
    parameter int unsigned X_MAX     = 600,
    parameter int unsigned Y_MIN     = 20,
    parameter int unsigned Y_MAX     = 440,
    parameter int unsigned INIT_X    = 300,
    parameter int unsigned INIT_Y    = 200,
    parameter int unsigned MAX_TRIES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rand_x,
    input  logic [8:0] rand_y,
    input  logic       spawn_req,
    output logic       occ_query_valid,
    output logic [9:0] occ_query_x,
    output logic [8:0] occ_query_y,
    input  logic       occ_resp_valid,
    input  logic       occ_hit,
    output logic [9:0] food_x,
    output logic [8:0] food_y,
    output logic       food_valid,
    output logic       spawn_busy,
    output logic       spawn_fail,
    output logic [2:0] dbg_state
);
    localparam logic [9:0] GRID_X = 10'(GRID);
    localparam logic [8:0] GRID_Y = 9'(GRID);
    localparam logic [9:0] XMIN   = 10'(X_MIN);
    localparam logic [9:0] XMAX   = 10'(X_MAX);
    localparam logic [8:0] YMIN   = 9'(Y_MIN);
    localparam logic [8:0] YMAX   = 9'(Y_MAX);
    localparam logic [7:0] TRIES  = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_QUERY  = 3'd2,
        S_COMMIT = 3'd3,
        S_FAIL   = 3'd4
`ifdef FOOD_SCAN_FALLBACK_EN
        ,S_SCAN  = 3'd5
`endif
    } state_t;

    state_t     r_state;
    logic [7:0] r_tries;
    logic [9:0] r_cand_x;
    logic [8:0] r_cand_y;
    logic [9:0] r_food_x;
    logic [8:0] r_food_y;
    logic       r_food_valid;
    logic       r_busy;
    logic       r_fail;
    logic       r_qv;

    // Snap down to the grid, then clamp into the legal play area.
    logic [9:0] w_snap_x;
    logic [8:0] w_snap_y;
    logic [9:0] w_cand_x;
    logic [8:0] w_cand_y;
    assign w_snap_x = rand_x - (rand_x % GRID_X);
    assign w_snap_y = rand_y - (rand_y % GRID_Y);
    assign w_cand_x = (w_snap_x < XMIN) ? XMIN : ((w_snap_x > XMAX) ? XMAX : w_snap_x);
    assign w_cand_y = (w_snap_y < YMIN) ? YMIN : ((w_snap_y > YMAX) ? YMAX : w_snap_y);

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam int unsigned SCAN_CELLS = ((X_MAX - X_MIN) / GRID + 1) * ((Y_MAX - Y_MIN) / GRID + 1);
    localparam logic [9:0]  SCAN_LAST  = 10'(SCAN_CELLS);

    // Scan walks row-major: x first, wrapping into the next row, then back to the top row.
    logic [9:0] r_scan_cnt;
    logic [9:0] w_step_x;
    logic [8:0] w_step_y;
    logic [9:0] w_next_x;
    logic [8:0] w_next_y;
    assign w_step_x = r_cand_x + GRID_X;
    assign w_step_y = r_cand_y + GRID_Y;
    assign w_next_x = (w_step_x > XMAX) ? XMIN : w_step_x;
    assign w_next_y = (w_step_x > XMAX) ? ((w_step_y > YMAX) ? YMIN : w_step_y) : r_cand_y;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tries      <= '0;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_food_x     <= 10'(INIT_X);
            r_food_y     <= 9'(INIT_Y);
            r_food_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_fail       <= 1'b0;
            r_qv         <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            r_scan_cnt   <= '0;
`endif
        end else begin
            r_fail <= 1'b0;
            case (r_state)
                // COMMIT already reports not-busy, so it accepts a new request like IDLE.
                S_IDLE, S_COMMIT: begin
                    if (spawn_req) begin
                        r_state      <= S_SAMPLE;
                        r_food_valid <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SAMPLE: begin
                    r_cand_x <= w_cand_x;
                    r_cand_y <= w_cand_y;
                    r_tries  <= r_tries + 8'd1;
                    r_qv     <= 1'b1;
                    r_state  <= S_QUERY;
                end
                S_QUERY: begin
                    if (occ_resp_valid) begin
                        r_qv <= 1'b0;
                        if (!occ_hit) begin
                            r_food_x     <= r_cand_x;
                            r_food_y     <= r_cand_y;
                            r_food_valid <= 1'b1;
                            r_busy       <= 1'b0;
                            r_tries      <= '0;
                            r_state      <= S_COMMIT;
`ifdef FOOD_SCAN_FALLBACK_EN
                            r_scan_cnt   <= '0;
                        end else if (r_scan_cnt != '0) begin
                            if (r_scan_cnt == SCAN_LAST) begin
                                r_fail     <= 1'b1;
                                r_tries    <= '0;
                                r_scan_cnt <= '0;
                                r_state    <= S_FAIL;
                            end else begin
                                r_state <= S_SCAN;
                            end
`endif
                        end else if (r_tries < TRIES) begin
                            r_state <= S_SAMPLE;
                        end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
                            r_state <= S_SCAN;
`else
                            r_fail  <= 1'b1;
                            r_tries <= '0;
                            r_state <= S_FAIL;
`endif
                        end
                    end
                end
`ifdef FOOD_SCAN_FALLBACK_EN
                S_SCAN: begin
                    r_cand_x   <= w_next_x;
                    r_cand_y   <= w_next_y;
                    r_scan_cnt <= r_scan_cnt + 10'd1;
                    r_qv       <= 1'b1;
                    r_state    <= S_QUERY;
                end
`endif
                S_FAIL: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign occ_query_valid = r_qv;
    assign occ_query_x     = r_cand_x;
    assign occ_query_y     = r_cand_y;
    assign food_x          = r_food_x;
    assign food_y          = r_food_y;
    assign food_valid      = r_food_valid;
    assign spawn_busy      = r_busy;
    assign spawn_fail      = r_fail;
    assign dbg_state       = r_state;
endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: a behavioural occupancy responder plus scoreboards for query candidates and committed food.
// Covers both builds of FOOD_SCAN_FALLBACK_EN in the exhaustion step.
module tb_food_spawner;
    logic       clk;
    logic       rst;
    logic [9:0] rand_x;
    logic [8:0] rand_y;
    logic       spawn_req;
    logic       occ_query_valid;
    logic [9:0] occ_query_x;
    logic [8:0] occ_query_y;
    logic       occ_resp_valid;
    logic       occ_hit;
    logic [9:0] food_x;
    logic [8:0] food_y;
    logic       food_valid;
    logic       spawn_busy;
    logic       spawn_fail;
    logic [2:0] dbg_state;

    food_spawner dut (
        .clk(clk), .rst(rst), .rand_x(rand_x), .rand_y(rand_y), .spawn_req(spawn_req),
        .occ_query_valid(occ_query_valid), .occ_query_x(occ_query_x), .occ_query_y(occ_query_y),
        .occ_resp_valid(occ_resp_valid), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .spawn_busy(spawn_busy), .spawn_fail(spawn_fail), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_queries = 0;
    int fail_cnt = 0;
    int fail_run = 0;
    int last_fail_width = 0;
    int lat = 1;
    bit resp_en = 1'b1;

    logic [18:0] exp_cand_q[$];
    logic [18:0] exp_food_q[$];
    logic [18:0] rand_q[$];
    logic        hit_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic pulse_spawn();
        @(negedge clk) spawn_req = 1'b1;
        @(negedge clk) spawn_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (spawn_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(spawn_busy), 32'd0);
    endtask

    task automatic expect_place(input logic [9:0] x, input logic [8:0] y);
        exp_cand_q.push_back({x, y});
        exp_food_q.push_back({x, y});
    endtask

    // Occupancy responder: answers each query after lat extra cycles and checks the candidate.
    initial begin
        int  wait_cnt;
        bit  seen;
        logic [18:0] c;
        wait_cnt = 0;
        seen = 1'b0;
        occ_resp_valid = 1'b0;
        occ_hit = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                occ_resp_valid = 1'b0;
                occ_hit = 1'b0;
                seen = 1'b0;
                wait_cnt = 0;
            end else if (occ_resp_valid) begin
                occ_resp_valid = 1'b0;
                occ_hit = 1'b0;
            end else if (occ_query_valid && resp_en) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_cand_q.size() > 0) begin
                        c = exp_cand_q.pop_front();
                        chk("query_x", 32'(occ_query_x), 32'(c[18:9]));
                        chk("query_y", 32'(occ_query_y), 32'(c[8:0]));
                    end else begin
                        chk("unexpected_query", 32'd1, 32'd0);
                    end
                end
                if (wait_cnt >= lat) begin
                    occ_resp_valid = 1'b1;
                    occ_hit = (hit_q.size() > 0) ? hit_q.pop_front() : 1'b0;
                    n_queries++;
                    seen = 1'b0;
                    wait_cnt = 0;
                    if (occ_hit && rand_q.size() > 0) {rand_x, rand_y} = rand_q.pop_front();
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Scoreboard: each rising food_valid outside reset is a commit to compare.
    initial begin
        logic prev_fv;
        logic prev_rst;
        logic [18:0] e;
        prev_fv = 1'b1;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && prev_rst && food_valid && !prev_fv) begin
                if (exp_food_q.size() > 0) begin
                    e = exp_food_q.pop_front();
                    chk("food_x", 32'(food_x), 32'(e[18:9]));
                    chk("food_y", 32'(food_y), 32'(e[8:0]));
                end else begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end
            end
            if (spawn_fail) fail_run++;
            else begin
                if (fail_run != 0) begin
                    fail_cnt++;
                    last_fail_width = fail_run;
                end
                fail_run = 0;
            end
            prev_fv = food_valid;
            prev_rst = rst;
        end
    end

    initial begin
        int q0;
        int f0;
        int n;
        rst = 1'b0;
        spawn_req = 1'b0;
        rand_x = 10'd20;
        rand_y = 9'd20;

        // 1: reset state
        repeat (2) @(negedge clk);
        chk("rst_food_x", 32'(food_x), 32'd300);
        chk("rst_food_y", 32'(food_y), 32'd200);
        chk("rst_food_valid", 32'(food_valid), 32'd1);
        chk("rst_busy", 32'(spawn_busy), 32'd0);
        chk("rst_query_valid", 32'(occ_query_valid), 32'd0);
        chk("rst_fail", 32'(spawn_fail), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // 2: free on first try, exact cycle timing
        lat = 1;
        rand_x = 10'd347;
        rand_y = 9'd233;
        expect_place(10'd340, 9'd220);
        pulse_spawn();
        chk("n1_food_valid", 32'(food_valid), 32'd0);
        chk("n1_busy", 32'(spawn_busy), 32'd1);
        chk("n1_query_valid", 32'(occ_query_valid), 32'd0);
        @(negedge clk);
        chk("n2_query_valid", 32'(occ_query_valid), 32'd1);
        chk("n2_query_x", 32'(occ_query_x), 32'd340);
        chk("n2_query_y", 32'(occ_query_y), 32'd220);
        @(negedge clk);
        chk("n3_query_valid", 32'(occ_query_valid), 32'd1);
        chk("n3_food_valid", 32'(food_valid), 32'd0);
        @(negedge clk);
        chk("n4_food_valid", 32'(food_valid), 32'd1);
        chk("n4_busy", 32'(spawn_busy), 32'd0);
        chk("n4_query_valid", 32'(occ_query_valid), 32'd0);

        // 3: clamp at both ends of the range
        rand_x = 10'd619;
        rand_y = 9'd459;
        expect_place(10'd600, 9'd440);
        pulse_spawn();
        wait_idle("clamp_hi_idle", 50);
        rand_x = 10'd20;
        rand_y = 9'd20;
        expect_place(10'd20, 9'd20);
        pulse_spawn();
        wait_idle("clamp_lo_idle", 50);
        chk("clamp_lo_food_x", 32'(food_x), 32'd20);

        // 4: two hits then free, each retry from a fresh sample
        lat = 2;
        rand_x = 10'd105;
        rand_y = 9'd65;
        exp_cand_q.push_back({10'd100, 9'd60});
        exp_cand_q.push_back({10'd240, 9'd320});
        expect_place(10'd400, 9'd180);
        hit_q.push_back(1'b1);
        hit_q.push_back(1'b1);
        hit_q.push_back(1'b0);
        rand_q.push_back({10'd255, 9'd333});
        rand_q.push_back({10'd410, 9'd199});
        q0 = n_queries;
        pulse_spawn();
        wait_idle("retry_idle", 100);
        chk("retry_queries", 32'(n_queries - q0), 32'd3);

        // 5: exhaustion
        lat = 1;
        q0 = n_queries;
        f0 = fail_cnt;
`ifdef FOOD_SCAN_FALLBACK_EN
        rand_x = 10'd619;
        rand_y = 9'd459;
        for (int i = 0; i < 15; i++) begin
            exp_cand_q.push_back({10'd600, 9'd440});
            hit_q.push_back(1'b1);
        end
        hit_q.push_back(1'b0);
        expect_place(10'd20, 9'd20);
        pulse_spawn();
        wait_idle("scan_idle", 300);
        chk("scan_queries", 32'(n_queries - q0), 32'd16);
        chk("scan_no_fail", 32'(fail_cnt - f0), 32'd0);
        chk("scan_food_valid", 32'(food_valid), 32'd1);
`else
        rand_x = 10'd53;
        rand_y = 9'd47;
        for (int i = 0; i < 15; i++) begin
            exp_cand_q.push_back({10'd40, 9'd40});
            hit_q.push_back(1'b1);
        end
        pulse_spawn();
        wait_idle("exhaust_idle", 300);
        @(negedge clk);
        chk("exhaust_queries", 32'(n_queries - q0), 32'd15);
        chk("exhaust_fail_count", 32'(fail_cnt - f0), 32'd1);
        chk("exhaust_fail_width", 32'(last_fail_width), 32'd1);
        chk("exhaust_food_valid", 32'(food_valid), 32'd0);
        chk("exhaust_food_x_held", 32'(food_x), 32'd400);
        chk("exhaust_food_y_held", 32'(food_y), 32'd180);
`endif

        // 6a: spawn_req while busy is dropped
        lat = 3;
        rand_x = 10'd87;
        rand_y = 9'd91;
        expect_place(10'd80, 9'd80);
        q0 = n_queries;
        pulse_spawn();
        @(negedge clk);
        rand_x = 10'd555;
        rand_y = 9'd255;
        spawn_req = 1'b1;
        @(negedge clk) spawn_req = 1'b0;
        wait_idle("busy_ignore_idle", 50);
        repeat (6) @(negedge clk);
        chk("busy_ignore_queries", 32'(n_queries - q0), 32'd1);
        chk("busy_ignore_busy", 32'(spawn_busy), 32'd0);

        // 6b: reset while a query is outstanding
        resp_en = 1'b0;
        rand_x = 10'd519;
        rand_y = 9'd399;
        pulse_spawn();
        n = 0;
        while (!occ_query_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_query_valid", 32'(occ_query_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_query_valid", 32'(occ_query_valid), 32'd0);
        chk("async_food_x", 32'(food_x), 32'd300);
        chk("async_food_y", 32'(food_y), 32'd200);
        chk("async_food_valid", 32'(food_valid), 32'd1);
        chk("async_busy", 32'(spawn_busy), 32'd0);
        @(negedge clk) rst = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);

        // Recovery after reset
        lat = 1;
        expect_place(10'd500, 9'd380);
        pulse_spawn();
        wait_idle("recover_idle", 50);
        @(negedge clk);
        chk("recover_food_valid", 32'(food_valid), 32'd1);
        chk("cand_q_drained", 32'(exp_cand_q.size()), 32'd0);
        chk("food_q_drained", 32'(exp_food_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
